// File: rtl/imm_pkg.sv
// rtl/imm_pkg.sv - immediate class constants, field widths and encoder FSM states
package imm_pkg;

   localparam logic [1:0] IMM_DP8  = 2'd0;
   localparam logic [1:0] IMM_DP12 = 2'd1;
   localparam logic [1:0] IMM_BR   = 2'd2;

   localparam int IMM_W = 24;
   localparam int ROT_W = 4;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SEARCH = 2'd1,
      ST_DONE   = 2'd2
   } imm_state_e;

endpackage

// File: rtl/imm_encoder.sv
// rtl/imm_encoder.sv - encodes a 32-bit constant into the 24-bit immediate field of a class
// Class 0 searches even left-rotations for an 8-bit fit; the other classes resolve in one SEARCH cycle.
module imm_encoder
   import imm_pkg::*;
#(
   parameter bit ROT_EN    = 1'b1,
   parameter int ROT_STEPS = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [1:0]       imm_src,
   input  logic [31:0]      value,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [IMM_W-1:0] imm,
   output logic             ok
);

   imm_state_e       r_state;
   imm_state_e       w_state_nxt;
   logic [31:0]      r_rreg;
   logic [ROT_W-1:0] r_rot;
   logic [1:0]       r_src;
   logic             r_tested;
   logic             r_hit;
   logic             r_hit_last;
   logic [ROT_W-1:0] r_hit_rot;
   logic [7:0]       r_hit_byte;
   logic [IMM_W-1:0] r_imm;
   logic             r_ok;

   logic             w_accept;
   logic             w_last_cand;
   logic             w_res_load;
   logic [IMM_W-1:0] w_res_imm;
   logic             w_res_ok;
   logic [IMM_W:0]   w_fixed;

   function automatic logic [IMM_W:0] f_encode_fixed(input logic [1:0] src, input logic [31:0] v);
      logic [IMM_W:0] res;
      res = '0;
      case (src)
         IMM_DP12: if (v[31:12] == 20'd0) res = {1'b1, 12'd0, v[11:0]};
         IMM_BR:   if (v[1:0] == 2'd0 && v[31:26] == 6'd0) res = {1'b1, v[25:2]};
         default:  res = '0;
      endcase
      return res;
   endfunction

   assign w_accept    = in_valid && (r_state == ST_IDLE);
   assign w_last_cand = (ROT_EN == 1'b0) || (r_rot == ROT_W'(ROT_STEPS - 1));
   assign w_fixed     = f_encode_fixed(r_src, r_rreg);

   // Decisions use the zero test registered on the previous cycle, so each
   // candidate costs one cycle plus one cycle of pipeline before DONE.
   always_comb begin
      w_state_nxt = r_state;
      w_res_load  = 1'b0;
      w_res_imm   = '0;
      w_res_ok    = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (w_accept) w_state_nxt = ST_SEARCH;
         end
         ST_SEARCH: begin
            if (r_src != IMM_DP8) begin
               w_res_load  = 1'b1;
               w_res_imm   = w_fixed[IMM_W-1:0];
               w_res_ok    = w_fixed[IMM_W];
               w_state_nxt = ST_DONE;
            end else if (r_tested && r_hit) begin
               w_res_load  = 1'b1;
               w_res_imm   = {12'd0, r_hit_rot, r_hit_byte};
               w_res_ok    = 1'b1;
               w_state_nxt = ST_DONE;
            end else if (r_tested && r_hit_last) begin
               w_res_load  = 1'b1;
               w_state_nxt = ST_DONE;
            end
         end
         ST_DONE: begin
            if (out_ready) w_state_nxt = ST_IDLE;
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= ST_IDLE;
         r_rreg     <= '0;
         r_rot      <= '0;
         r_src      <= '0;
         r_tested   <= 1'b0;
         r_hit      <= 1'b0;
         r_hit_last <= 1'b0;
         r_hit_rot  <= '0;
         r_hit_byte <= '0;
         r_imm      <= '0;
         r_ok       <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         if (w_accept) begin
            r_rreg   <= value;
            r_src    <= imm_src;
            r_rot    <= '0;
            r_tested <= 1'b0;
         end else if (r_state == ST_SEARCH && r_src == IMM_DP8) begin
            r_tested   <= 1'b1;
            r_hit      <= (r_rreg[31:8] == 24'd0);
            r_hit_last <= w_last_cand;
            r_hit_rot  <= r_rot;
            r_hit_byte <= r_rreg[7:0];
            if (!w_last_cand) begin
               r_rreg <= {r_rreg[29:0], r_rreg[31:30]};
               r_rot  <= r_rot + 1'b1;
            end
         end
         if (w_res_load) begin
            r_imm <= w_res_imm;
            r_ok  <= w_res_ok;
         end
      end
   end

   assign in_ready  = (r_state == ST_IDLE);
   assign out_valid = (r_state == ST_DONE);
   assign imm       = r_imm;
   assign ok        = r_ok;

endmodule
